// File: rtl/aes_cmd_queue.sv
// Command queue in front of aes_build: buffers {func,text,key} entries
// and issues them one at a time, holding each until call_complete.
module aes_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     eph1,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_func,
  input  logic [127:0]             req_text,
  input  logic [127:0]             req_key,
  output logic [1:0]               aes_func,
  output logic [127:0]             aes_text,
  output logic [127:0]             aes_key,
  input  logic                     aes_call_complete,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     req_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_nxt;

  logic [1:0]   mem_func [DEPTH];
  logic [127:0] mem_text [DEPTH];
  logic [127:0] mem_key  [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic legal, push, bad, pop, done;

  assign legal     = (req_func == 2'h1) || (req_func == 2'h2);
  assign req_ready = (count < CW'(DEPTH));
  assign push      = req_valid & req_ready & legal;
  assign bad       = req_valid & req_ready & ~legal;
  assign busy      = (state == BUSY);

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (aes_call_complete) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge eph1) begin
    if (push) begin
      mem_func[wr_ptr] <= req_func;
      mem_text[wr_ptr] <= req_text;
      mem_key[wr_ptr]  <= req_key;
    end
  end

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      aes_func <= 2'h0;
      aes_text <= '0;
      aes_key  <= '0;
      req_err  <= 1'b0;
    end else begin
      req_err <= bad;
      if (pop) begin
        aes_func <= mem_func[rd_ptr];
        aes_text <= mem_text[rd_ptr];
        aes_key  <= mem_key[rd_ptr];
      end else if (done) begin
        aes_func <= 2'h0;
      end
    end
  end

endmodule

// File: tb/tb_aes_cmd_queue.sv
// Scoreboard bench for aes_cmd_queue: pushes record expected issues,
// a monitor compares each new issue and checks in-flight stability.
module tb_aes_cmd_queue;

  logic         eph1;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_func;
  logic [127:0] req_text;
  logic [127:0] req_key;
  logic [1:0]   aes_func;
  logic [127:0] aes_text;
  logic [127:0] aes_key;
  logic         aes_call_complete;
  logic [2:0]   count;
  logic         busy;
  logic         req_err;

  int checks = 0;
  int failures = 0;

  logic [257:0] sb [$];

  logic [1:0]   prev_func;
  logic [127:0] prev_text;
  logic [127:0] prev_key;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  aes_cmd_queue #(.DEPTH(4)) dut (
    .eph1              (eph1),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_func          (req_func),
    .req_text          (req_text),
    .req_key           (req_key),
    .aes_func          (aes_func),
    .aes_text          (aes_text),
    .aes_key           (aes_key),
    .aes_call_complete (aes_call_complete),
    .count             (count),
    .busy              (busy),
    .req_err           (req_err)
  );

  initial begin
    eph1 = 1'b0;
    forever #5 eph1 = ~eph1;
  end

  task automatic chk(input string name,
                     input logic [259:0] act,
                     input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge eph1) begin
    if (reset) begin
      prev_func = 2'h0;
    end else begin
      if (aes_func != 2'h0 && prev_func == 2'h0) begin
        if (sb.size() == 0) begin
          chk("unexpected_issue", {aes_func, aes_text, aes_key}, '0);
        end else begin
          chk("issue", {aes_func, aes_text, aes_key}, sb.pop_front());
        end
      end else if (aes_func != 2'h0) begin
        chk("hold", {aes_func, aes_text, aes_key},
            {prev_func, prev_text, prev_key});
      end
      prev_func = aes_func;
      prev_text = aes_text;
      prev_key  = aes_key;
    end
  end

  task automatic step();
    @(posedge eph1);
    #1;
  endtask

  task automatic push(input logic [1:0] f,
                      input logic [127:0] t,
                      input logic [127:0] k);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_func  = f;
    req_text  = t;
    req_key   = k;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("push_ready", req_ready, 1);
    if (req_ready && (f == 2'h1 || f == 2'h2))
      sb.push_back({f, t, k});
    step();
    req_valid = 1'b0;
  endtask

  task automatic complete();
    aes_call_complete = 1'b1;
    step();
    aes_call_complete = 1'b0;
    chk("done_func", aes_func, 0);
    chk("done_busy", busy, 0);
  endtask

  task automatic wait_issue();
    int n;
    n = 0;
    while (aes_func == 2'h0 && n < 50) begin
      step();
      n++;
    end
    chk("issue_timeout", busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_func = 2'h0;
    req_text = '0;
    req_key = '0;
    aes_call_complete = 1'b0;
    step();
    step();
    chk("rst_func", aes_func, 0);
    chk("rst_text", {aes_text, aes_key}, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_err", req_err, 0);
    reset = 1'b0;

    // single encrypt
    push(2'h1, PT, KEY);
    step();
    chk("enc_func", aes_func, 1);
    chk("enc_busy", busy, 1);
    chk("enc_count", count, 0);
    complete();

    // decrypt, long call, then nothing more
    push(2'h2, CT, KEY);
    step();
    repeat (16) step();
    chk("dec_hold", aes_func, 2);
    complete();
    repeat (3) step();
    chk("idle_func", aes_func, 0);
    chk("idle_count", count, 0);
    chk("idle_busy", busy, 0);

    // fill while busy, fifth held off
    push(2'h1, 128'hA, 128'hA0);
    step();
    push(2'h2, 128'hB, 128'hB0);
    push(2'h1, 128'hC, 128'hC0);
    push(2'h2, 128'hD, 128'hD0);
    push(2'h1, 128'hE, 128'hE0);
    chk("full_count", count, 4);
    chk("full_ready", req_ready, 0);
    req_valid = 1'b1;
    req_func  = 2'h2;
    req_text  = 128'hF;
    req_key   = 128'hF0;
    step();
    step();
    chk("held_count", count, 4);
    complete();
    chk("held_count2", count, 4);
    push(2'h2, 128'hF, 128'hF0);
    chk("refill_count", count, 4);
    repeat (4) begin
      complete();
      wait_issue();
    end
    complete();

    // illegal funcs while busy
    push(2'h1, 128'h1111, 128'h2222);
    step();
    push(2'h3, 128'h3333, 128'h4444);
    chk("ill_count", count, 0);
    chk("ill_err", req_err, 1);
    chk("ill_func", aes_func, 1);
    step();
    chk("ill_err_clr", req_err, 0);
    push(2'h0, 128'h5555, 128'h6666);
    chk("ill0_err", req_err, 1);
    chk("ill0_count", count, 0);
    complete();

    // simultaneous push/pop at count=2
    push(2'h1, 128'h10, 128'h100);
    step();
    push(2'h2, 128'h20, 128'h200);
    push(2'h1, 128'h30, 128'h300);
    chk("pp_count_pre", count, 2);
    complete();
    chk("pp_count_idle", count, 2);
    push(2'h2, 128'h40, 128'h400);
    chk("pp_count", count, 2);
    chk("pp_busy", busy, 1);
    complete();
    wait_issue();
    complete();
    wait_issue();
    complete();

    // reset mid-call with three queued
    push(2'h1, 128'h50, 128'h500);
    step();
    push(2'h2, 128'h60, 128'h600);
    push(2'h1, 128'h70, 128'h700);
    push(2'h2, 128'h80, 128'h800);
    chk("pre_rst_count", count, 3);
    reset = 1'b1;
    #1;
    chk("mrst_func", aes_func, 0);
    chk("mrst_count", count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", req_ready, 1);
    sb.delete();
    step();
    aes_call_complete = 1'b1;
    reset = 1'b0;
    step();
    aes_call_complete = 1'b0;
    step();
    chk("post_rst_func", aes_func, 0);
    chk("post_rst_count", count, 0);
    push(2'h1, 128'h90, 128'h900);
    chk("first_push", count, 1);
    wait_issue();
    complete();
    step();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_cmd_queue.md
AES_CMD_QUEUE -- requirements
Module: aes_cmd_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queued command entries (power of two, 2..16).
REQ-002 The block SHALL have port eph1  in  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port reset  in  1  asynchronous active-high reset.
REQ-004 The block SHALL have port req_valid  in  1  command offered this cycle.
REQ-005 The block SHALL have port req_ready  out  1  queue can accept a command this cycle.
REQ-006 The block SHALL have port req_func  in  2  2'h1 encrypt, 2'h2 decrypt, 2'h0/2'h3 illegal.
REQ-007 The block SHALL have port req_text  in  128  plaintext (encrypt) or ciphertext (decrypt).
REQ-008 The block SHALL have port req_key  in  128  AES-128 key for this command.
REQ-009 The block SHALL have port aes_func  out  2  func to aes_build; 2'h0 means no call.
REQ-010 The block SHALL have port aes_text  out  128  text_in to aes_build.
REQ-011 The block SHALL have port aes_key  out  128  true_key to aes_build.
REQ-012 The block SHALL have port aes_call_complete  in  1  call_complete from aes_build.
REQ-013 The block SHALL have port count  out  $clog2(DEPTH)+1  entries queued and not yet issued.
REQ-014 The block SHALL have port busy  out  1  a call is in flight to aes_build.
REQ-015 The block SHALL have port req_err  out  1  one-cycle pulse marking a rejected illegal command.

Function
REQ-016 The queue SHALL be a circular FIFO of DEPTH entries {func, text, key}, with write and read pointers wrapping modulo DEPTH.
REQ-017 req_ready SHALL equal (count < DEPTH), derived from registered count only, not from a same-cycle pop.
REQ-018 A push SHALL occur at the rising edge where req_valid & req_ready & req_func is 2'h1 or 2'h2.
REQ-019 A command with req_func 2'h0 or 2'h3 presented with req_valid & req_ready SHALL NOT be enqueued, and req_err SHALL be 1 for exactly the following cycle.
REQ-020 The FSM SHALL have two states, IDLE (busy=0) and BUSY (busy=1).
REQ-021 In IDLE with count>0 at an edge, the block SHALL pop the head into the aes_func/aes_text/aes_key registers and go to BUSY, so the outputs are valid the cycle after the edge.
REQ-022 Minimum latency SHALL be 2 edges: push at edge N, issue at edge N+1.
REQ-023 In BUSY, aes_func/aes_text/aes_key SHALL hold stable until the edge where aes_call_complete=1; at that edge aes_func SHALL become 2'h0 and the state SHALL become IDLE.
REQ-024 After every completion, IDLE SHALL last at least one cycle with aes_func=2'h0 before the next issue.
REQ-025 In IDLE, aes_func SHALL be 2'h0, aes_text/aes_key SHALL hold their last values, and aes_call_complete SHALL be ignored.
REQ-026 On a simultaneous push and pop, count SHALL be unchanged and both entries SHALL be preserved in order.
REQ-027 A push SHALL be accepted while BUSY and SHALL NOT disturb the in-flight outputs.
REQ-028 Commands SHALL issue in strict arrival order.
REQ-029 count SHALL never exceed DEPTH or go below 0.

Reset
REQ-030 On reset assertion, asynchronously: state SHALL be IDLE, pointers and count SHALL be 0, aes_func SHALL be 2'h0, aes_text/aes_key SHALL be 0, req_err SHALL be 0, busy SHALL be 0, and req_ready SHALL be 1.
REQ-031 Reset during BUSY SHALL abandon the in-flight call and all queued entries, with no completion tracked afterward.
REQ-032 The first push SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-033 The bench SHALL cover: push {1, 00112233445566778899aabbccddeeff, 000102030405060708090a0b0c0d0e0f} -> next cycle aes_func=1 with that text and key, busy=1, count=0.
REQ-034 The bench SHALL cover: push {2, 69c4e0d86a7b0430d8cdb78070b4c55a, same key}, then pulse aes_call_complete after 16 cycles -> aes_func=0 at that edge, busy=0, then no issue.
REQ-035 The bench SHALL cover: 5 pushes with DEPTH=4 while BUSY -> req_ready=0 after 4th push, 5th held off until a pop; issue order matches push order.
REQ-036 The bench SHALL cover: push with req_func=3 -> count unchanged, req_err=1 for one cycle, aes_func unaffected.
REQ-037 The bench SHALL cover: push and pop on the same edge with count=2 -> count stays 2, and a wrap-around past index 3 preserves data.
REQ-038 The bench SHALL cover: assert reset mid-BUSY with count=3 -> immediately aes_func=0, count=0, busy=0, req_ready=1.
